spw_ds_tx: RTL and testbench
============================

Name: spw_ds_tx

Overview:
SpaceWire data-strobe transmitter, one per channel of the SpaceWire node. It serialises NULLs, FCTs, N-chars (data/EOP/EEP) and time-codes onto the non-differential Do/So lines, which feed the LVDS output pads. It is the transmit counterpart of the DS receiver/decoder. It also enforces host-side credit: 8 credits per FCT received, one credit consumed per N-char sent.

Parameters:
DIV, 10, gclk cycles per transmitted bit (>=2)
CREDIT_MAX, 56, maximum outstanding N-char credit

Ports:
gclk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high
tx_en  input  1  transmitter enabled (Started/Connecting/Run); low = link reset
nchar_en  input  1  N-chars and time-codes permitted (Run state)
fct_req  input  1  pulse: queue one FCT for transmission
rx_fct  input  1  pulse: FCT received by receiver, credit += 8
nchar_valid  input  1  N-char offered
nchar_data  input  9  [8]=control flag; [7:0] data; if [8]=1: [0]=0 EOP, [0]=1 EEP
nchar_ready  output  1  N-char accepted this cycle when nchar_valid=1
tick_in  input  1  pulse: send time-code
time_in  input  8  time-code value, captured on tick_in
fct_sent  output  1  one-cycle pulse when an FCT starts transmission
credit  output  6  current credit count
credit_err  output  1  one-cycle pulse: rx_fct would exceed CREDIT_MAX
Do  output  1  data line
So  output  1  strobe line

Behaviour:
- Reset (or tx_en=0, which has the same effect): Do=0, So=0, credit=0, nchar_ready=0, fct_sent=0, credit_err=0, pending FCT/tick cleared, parity accumulator=0, bit counter=0.
- tx_en=0 mid-character: transmission is abandoned. The next cycle matches the reset state.
- Bit timing: divider counts 0..DIV-1. A new bit is driven when the divider wraps. The first bit is driven on the cycle after tx_en is first sampled high. Each bit is held for exactly DIV cycles.
- DS rule: if the new D equals the previous D, S toggles; otherwise S holds. Do^So therefore toggles on every bit boundary.
- Character framing, bits sent left to right:
  - data: P,0,d0..d7
  - FCT: P,1,0,0
  - EOP: P,1,1,0
  - EEP: P,1,0,1
  - ESC: P,1,1,1
  - NULL = ESC+FCT as one indivisible 8-bit unit
  - time-code = ESC + data char (t0..t7) as one indivisible 14-bit unit
- Parity: P = 1 ^ XOR(data bits of the previous character) ^ flag of the current character. The accumulator resets to 0 on enable, so the first NULL bits are 0,1,1,1,0,1,0,0.
- Selection happens only at a unit boundary, i.e. the last bit period of the current unit (or idle after enable). Priority:
  1. time-code: pending tick and nchar_en
  2. FCT: pending fct_req
  3. N-char: nchar_en, credit>0, nchar_valid
  4. NULL
- nchar_ready is combinational. It is high only in the selection cycle when no time-code or FCT is pending, nchar_en=1 and credit>0. The N-char is latched when nchar_valid&nchar_ready.
- fct_sent pulses in the selection cycle that picks an FCT.
- Pending flags:
  - fct_req sets the FCT flag; the flag clears when selected. A second fct_req while pending is not queued; one FCT is sent.
  - tick_in sets the tick flag and captures time_in. A new tick while pending overwrites time_in and keeps one flag.
- Credit:
  - rx_fct adds 8.
  - N-char acceptance subtracts 1.
  - If both occur in the same cycle, the net change is +7.
  - If the result would exceed CREDIT_MAX, credit is unchanged and credit_err pulses. The acceptance decrement still applies; credit_err is evaluated on credit+8-dec.
  - Credit never goes below 0, because ready requires credit>0.
- nchar_en dropping while a unit is in flight: that unit completes. Only NULL or FCT is selected afterwards.

Test Plan:
1. Reset, DIV=4, tx_en=1, nchar_en=0 -> Do bit sequence 0,1,1,1,0,1,0,0 repeating, 4 cycles per bit; Do^So toggles every bit; nchar_ready never high.
2. After NULLs, fct_req pulse -> fct_sent pulses at the next boundary; Do=0,1,0,0 is sent between NULLs; the next NULL starts with P=0.
3. nchar_en=1, rx_fct once (credit=8), offer 0x041 then EOP 0x100 -> data bits 1,0,1,0,0,0,0,0,1,0, then EOP 0,1,1,0; credit ends at 6.
4. Seven rx_fct pulses (credit=56), then an eighth -> credit_err pulses and credit stays at 56. Hold nchar_valid with credit=0 -> nchar_ready stays 0 and only NULLs are sent.
5. tick_in with time_in=0x05 while a data char is in flight, plus a simultaneous fct_req -> the time-code 14-bit unit (ESC + 0x05) is sent before the FCT; the N-char waits.
6. Deassert tx_en mid-data-char -> Do=So=0 and credit=0 the next cycle. Re-enable -> the stream restarts with 0,1,1,1,0,1,0,0.

Source files
------------

// File: rtl/spw_ds_tx.sv
// SpaceWire data-strobe transmitter: serialises NULL/FCT/N-char/time-code units onto Do/So
// and tracks the N-char credit granted by received FCTs.
module spw_ds_tx #(
  parameter int unsigned DIV        = 10,
  parameter int unsigned CREDIT_MAX = 56
) (
  input  logic       gclk,
  input  logic       reset,
  input  logic       tx_en,
  input  logic       nchar_en,
  input  logic       fct_req,
  input  logic       rx_fct,
  input  logic       nchar_valid,
  input  logic [8:0] nchar_data,
  output logic       nchar_ready,
  input  logic       tick_in,
  input  logic [7:0] time_in,
  output logic       fct_sent,
  output logic [5:0] credit,
  output logic       credit_err,
  output logic       Do,
  output logic       So
);

  localparam int unsigned   DW      = $clog2(DIV);
  localparam logic [DW-1:0] DivLast = DW'(DIV - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e         state_q, state_d;
  logic [DW-1:0]  div_q, div_d;
  logic [3:0]     rem_q, rem_d;
  logic [12:0]    sh_q, sh_d;
  logic           do_q, do_d, so_q, so_d;
  logic           par_q, par_d;
  logic           fct_pend_q, fct_pend_d;
  logic           tick_pend_q, tick_pend_d;
  logic [7:0]     time_q, time_d;
  logic [5:0]     credit_q, credit_d;

  logic           live, boundary, sel, pick_time, pick_fct, accept;
  logic [13:0]    unit;
  logic [3:0]     unit_len;
  logic           par_next, new_bit, emit;
  logic [6:0]     sum;

  always_comb begin
    live        = tx_en & ~reset;
    boundary    = (state_q == StIdle) || ((div_q == DivLast) && (rem_q == 4'd0));
    sel         = live & boundary;
    pick_time   = sel & tick_pend_q & nchar_en;
    pick_fct    = sel & ~pick_time & fct_pend_q;
    nchar_ready = sel & nchar_en & ~tick_pend_q & ~fct_pend_q & (credit_q != 6'd0);
    accept      = nchar_ready & nchar_valid;
    fct_sent    = pick_fct;

    // unit[i] is the i-th bit on the line; NULL's FCT parity is 0 since ESC data bits cancel.
    unit     = {6'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, par_q};
    unit_len = 4'd8;
    par_next = 1'b0;
    if (pick_time) begin
      unit     = {time_q, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, par_q};
      unit_len = 4'd14;
      par_next = ^time_q;
    end else if (pick_fct) begin
      unit     = {10'b0, 1'b0, 1'b0, 1'b1, par_q};
      unit_len = 4'd4;
    end else if (accept) begin
      if (!nchar_data[8]) begin
        unit     = {4'b0, nchar_data[7:0], 1'b0, ~par_q};
        unit_len = 4'd10;
        par_next = ^nchar_data[7:0];
      end else begin
        unit     = {10'b0, nchar_data[0], ~nchar_data[0], 1'b1, par_q};
        unit_len = 4'd4;
        par_next = 1'b1;
      end
    end

    sum        = {1'b0, credit_q} + (rx_fct ? 7'd8 : 7'd0) - {6'b0, accept};
    credit_err = live & rx_fct & (sum > 7'(CREDIT_MAX));

    state_d     = state_q;
    div_d       = div_q;
    rem_d       = rem_q;
    sh_d        = sh_q;
    do_d        = do_q;
    so_d        = so_q;
    par_d       = par_q;
    fct_pend_d  = fct_pend_q;
    tick_pend_d = tick_pend_q;
    time_d      = time_q;
    credit_d    = credit_q;
    new_bit     = 1'b0;
    emit        = 1'b0;

    if (!live) begin
      state_d     = StIdle;
      div_d       = '0;
      rem_d       = '0;
      sh_d        = '0;
      do_d        = 1'b0;
      so_d        = 1'b0;
      par_d       = 1'b0;
      fct_pend_d  = 1'b0;
      tick_pend_d = 1'b0;
      time_d      = '0;
      credit_d    = '0;
    end else begin
      fct_pend_d  = (fct_pend_q & ~pick_fct) | fct_req;
      tick_pend_d = (tick_pend_q & ~pick_time) | tick_in;
      if (tick_in) time_d = time_in;
      // An overflowing FCT is dropped, but a simultaneous acceptance still consumes credit.
      credit_d = credit_err ? (credit_q - {5'b0, accept}) : sum[5:0];
      if (sel) begin
        new_bit = unit[0];
        sh_d    = unit[13:1];
        rem_d   = unit_len - 4'd1;
        par_d   = par_next;
        div_d   = '0;
        state_d = StRun;
        emit    = 1'b1;
      end else if (div_q == DivLast) begin
        new_bit = sh_q[0];
        sh_d    = sh_q >> 1;
        rem_d   = rem_q - 4'd1;
        div_d   = '0;
        emit    = 1'b1;
      end else begin
        div_d = div_q + DW'(1);
      end
    end

    if (emit) begin
      do_d = new_bit;
      so_d = (new_bit == do_q) ? ~so_q : so_q;
    end
  end

  always_ff @(posedge gclk) begin
    if (reset) begin
      state_q     <= StIdle;
      div_q       <= '0;
      rem_q       <= '0;
      sh_q        <= '0;
      do_q        <= 1'b0;
      so_q        <= 1'b0;
      par_q       <= 1'b0;
      fct_pend_q  <= 1'b0;
      tick_pend_q <= 1'b0;
      time_q      <= '0;
      credit_q    <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      rem_q       <= rem_d;
      sh_q        <= sh_d;
      do_q        <= do_d;
      so_q        <= so_d;
      par_q       <= par_d;
      fct_pend_q  <= fct_pend_d;
      tick_pend_q <= tick_pend_d;
      time_q      <= time_d;
      credit_q    <= credit_d;
    end
  end

  assign Do     = do_q;
  assign So     = so_q;
  assign credit = credit_q;

endmodule

// File: tb/tb_spw_ds_tx.sv
// Directed bench for spw_ds_tx: decodes the DS line into characters and checks them against
// hand-computed codes ({parity, code}: data 0x0xx, EOP 0x100, FCT 0x102, ESC 0x103).
module tb_spw_ds_tx;

  localparam int unsigned DIV = 4;
  localparam logic [8:0] C_ESC = 9'h103;
  localparam logic [8:0] C_FCT = 9'h102;

  logic       gclk, reset, tx_en, nchar_en, fct_req, rx_fct, nchar_valid, tick_in;
  logic [8:0] nchar_data;
  logic [7:0] time_in;
  logic       nchar_ready, fct_sent, credit_err, Do, So;
  logic [5:0] credit;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int fct_cnt = 0;
  bit ready_bad = 0;

  logic       raw_q[$];
  logic [9:0] char_q[$];

  spw_ds_tx #(.DIV(DIV), .CREDIT_MAX(56)) dut (
    .gclk       (gclk),
    .reset      (reset),
    .tx_en      (tx_en),
    .nchar_en   (nchar_en),
    .fct_req    (fct_req),
    .rx_fct     (rx_fct),
    .nchar_valid(nchar_valid),
    .nchar_data (nchar_data),
    .nchar_ready(nchar_ready),
    .tick_in    (tick_in),
    .time_in    (time_in),
    .fct_sent   (fct_sent),
    .credit     (credit),
    .credit_err (credit_err),
    .Do         (Do),
    .So         (So)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;
  always @(posedge gclk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Line monitor: recovers bits from Do^So transitions and frames them into characters.
  logic       last_x = 1'b0;
  bit         have_prev = 0;
  int         prev_cyc = 0;
  int         nb = 0;
  logic [9:0] cb = '0;
  always @(posedge gclk) begin
    logic [8:0] code;
    #1;
    if (fct_sent) fct_cnt++;
    if (nchar_ready && !nchar_en) ready_bad = 1;
    if (reset || !tx_en) begin
      last_x = 1'b0; have_prev = 0; nb = 0;
    end else if ((Do ^ So) != last_x) begin
      last_x = Do ^ So;
      raw_q.push_back(Do);
      if (have_prev) check_eq("bit_period", cyc - prev_cyc, DIV);
      prev_cyc  = cyc;
      have_prev = 1;
      cb[nb] = Do;
      nb++;
      if (nb >= 2 && nb == (cb[1] ? 4 : 10)) begin
        if (cb[1]) begin
          case ({cb[2], cb[3]})
            2'b00:   code = 9'h102;
            2'b11:   code = 9'h103;
            2'b10:   code = 9'h100;
            default: code = 9'h101;
          endcase
        end else begin
          code = '0;
          for (int k = 0; k < 8; k++) code[k] = cb[k+2];
        end
        char_q.push_back({cb[0], code});
        nb = 0;
      end
    end
  end

  task automatic pop_raw(output logic b);
    int w = 0;
    while (raw_q.size() == 0 && w < 400) begin @(posedge gclk); w++; end
    check_eq("raw_avail", raw_q.size() != 0, 1);
    if (raw_q.size() != 0) b = raw_q.pop_front();
    else b = 1'bx;
  endtask

  task automatic pop_char(output logic [9:0] c);
    int w = 0;
    while (char_q.size() == 0 && w < 400) begin @(posedge gclk); w++; end
    check_eq("char_avail", char_q.size() != 0, 1);
    if (char_q.size() != 0) c = char_q.pop_front();
    else c = 'x;
  endtask

  // Flush, then consume up to the end of a fresh NULL so the next character starts a unit.
  task automatic sync_null();
    logic [9:0] c, prev;
    bit found = 0;
    char_q.delete();
    prev = '0;
    for (int i = 0; i < 20 && !found; i++) begin
      pop_char(c);
      if (prev[8:0] == C_ESC && c[8:0] == C_FCT) found = 1;
      prev = c;
    end
    check_eq("sync_null", found, 1);
  endtask

  task automatic next_non_null(output logic [9:0] c);
    logic [9:0] c2;
    bit done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      pop_char(c);
      if (c[8:0] != C_ESC) done = 1;
      else begin
        pop_char(c2);
        if (c2[8:0] != C_FCT) begin
          char_q.push_front(c2);
          done = 1;
        end
      end
    end
    check_eq("non_null_found", done, 1);
  endtask

  // Offer one N-char; returns just after the accepting edge with nchar_valid still high.
  task automatic send_nchar(input logic [8:0] d, input bit with_fct);
    int w = 0;
    @(negedge gclk);
    nchar_valid = 1'b1;
    nchar_data  = d;
    while (!nchar_ready && w < 400) begin @(negedge gclk); w++; end
    check_eq("ready_seen", nchar_ready, 1);
    if (with_fct) begin
      rx_fct = 1'b1;
      #1;
      check_eq("credit_err_accept", credit_err, 1);
    end
    @(posedge gclk);
    #1 rx_fct = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] null_bits;
    logic       b;
    logic [9:0] c;
    int         f0, w, n77;
    bit         rdy;

    null_bits = 8'b0010_1110;
    reset = 1'b1; tx_en = 1'b1; nchar_en = 1'b0; fct_req = 1'b0; rx_fct = 1'b0;
    nchar_valid = 1'b0; nchar_data = '0; tick_in = 1'b0; time_in = '0;

    // 1: reset state, then the NULL stream from enable
    repeat (3) @(negedge gclk);
    check_eq("rst_do", Do, 0);
    check_eq("rst_so", So, 0);
    check_eq("rst_credit", credit, 0);
    check_eq("rst_ready", nchar_ready, 0);
    check_eq("rst_fct_sent", fct_sent, 0);
    check_eq("rst_credit_err", credit_err, 0);
    raw_q.delete();
    reset = 1'b0;
    @(posedge gclk);
    #2;
    check_eq("first_bit_strobe", Do ^ So, 1);
    check_eq("first_bit_data", Do, 0);
    for (int i = 0; i < 16; i++) begin
      pop_raw(b);
      check_eq($sformatf("null_bit%0d", i), b, null_bits[i % 8]);
    end

    // 2: a queued FCT goes out between NULLs
    sync_null();
    f0 = fct_cnt;
    @(negedge gclk) fct_req = 1'b1;
    @(negedge gclk) fct_req = 1'b0;
    next_non_null(c);
    check_eq("fct_char", c, 10'h102);
    pop_char(c);
    check_eq("post_fct_esc", c, 10'h103);
    pop_char(c);
    check_eq("post_fct_fct", c, 10'h102);
    check_eq("fct_sent_count", fct_cnt - f0, 1);
    check_eq("ready_without_nchar_en", ready_bad, 0);

    // 3: data 0x41 then EOP with 8 credits
    @(negedge gclk); nchar_en = 1'b1; rx_fct = 1'b1;
    @(negedge gclk); rx_fct = 1'b0;
    check_eq("credit_after_fct", credit, 8);
    sync_null();
    send_nchar(9'h041, 0);
    send_nchar(9'h100, 0);
    @(negedge gclk) nchar_valid = 1'b0;
    next_non_null(c);
    check_eq("data_41", c, 10'h241);
    pop_char(c);
    check_eq("eop", c, 10'h100);
    check_eq("credit_after_two", credit, 6);

    // 4: drain to zero, stall, refill to the limit, overflow
    for (int i = 1; i <= 6; i++) send_nchar(9'(i), 0);
    check_eq("credit_drained", credit, 0);
    @(negedge gclk) nchar_data = 9'h077;
    rdy = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge gclk);
      if (nchar_ready) rdy = 1;
    end
    check_eq("ready_zero_credit", rdy, 0);
    n77 = 0;
    foreach (char_q[i]) if (char_q[i][8:0] == 9'h077) n77++;
    check_eq("no_char_zero_credit", n77, 0);
    nchar_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge gclk) rx_fct = 1'b1;
      #1 check_eq("credit_err_fill", credit_err, 0);
    end
    @(negedge gclk) rx_fct = 1'b0;
    check_eq("credit_full", credit, 56);
    @(negedge gclk) rx_fct = 1'b1;
    #1 check_eq("credit_err_over", credit_err, 1);
    @(negedge gclk) rx_fct = 1'b0;
    #1;
    check_eq("credit_held", credit, 56);
    check_eq("credit_err_clear", credit_err, 0);
    send_nchar(9'h0C3, 1);
    check_eq("credit_over_with_accept", credit, 55);
    @(negedge gclk) nchar_valid = 1'b0;

    // 5: time-code and FCT queued during a data char; time-code wins, N-char waits
    sync_null();
    send_nchar(9'h0AA, 0);
    f0 = fct_cnt;
    @(negedge gclk);
    tick_in = 1'b1; time_in = 8'h05; fct_req = 1'b1; nchar_data = 9'h033;
    @(negedge gclk);
    tick_in = 1'b0; fct_req = 1'b0; time_in = 8'hFF;
    w = 0;
    while (!nchar_ready && w < 400) begin @(negedge gclk); w++; end
    check_eq("ready_after_tc", nchar_ready, 1);
    @(negedge gclk) nchar_valid = 1'b0;
    next_non_null(c);
    check_eq("inflight_aa", c[8:0], 9'h0AA);
    pop_char(c);
    check_eq("tc_esc", c, 10'h103);
    pop_char(c);
    check_eq("tc_data", c, 10'h205);
    pop_char(c);
    check_eq("tc_then_fct", c, 10'h102);
    pop_char(c);
    check_eq("waiting_nchar", c, 10'h233);
    check_eq("fct_sent_tc", fct_cnt - f0, 1);
    check_eq("credit_after_tc", credit, 53);

    // 6: disable mid-character, then restart
    send_nchar(9'h0FF, 0);
    repeat (12) @(negedge gclk);
    tx_en = 1'b0;
    nchar_valid = 1'b0;
    @(posedge gclk);
    #2;
    check_eq("dis_do", Do, 0);
    check_eq("dis_so", So, 0);
    check_eq("dis_credit", credit, 0);
    check_eq("dis_ready", nchar_ready, 0);
    repeat (3) @(negedge gclk);
    raw_q.delete();
    tx_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pop_raw(b);
      check_eq($sformatf("restart_bit%0d", i), b, null_bits[i]);
    end
    check_eq("restart_credit", credit, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
